dac8564_scheduler: RTL and testbench
====================================

# dac8564_scheduler

Round-robin scheduler and serial engine for a quad 16-bit DAC8564 on one shared 3-wire serial bus (nSync/SClk/Data). Four independent requesters post 16-bit two's-complement channel values with a Req/Ack handshake. The block arbitrates between them, converts each value to offset binary, and shifts one 24-bit frame per grant. It sets the DAC broadcast-load bit on the frame that drains the pending queue, so all outputs updated in a burst change together. It replaces fixed four-frame sweeps in the analogue output path, so each channel updates only when its requester asks.

## Interface
- CLK_DIV, 1: Clk cycles per SClk half-period; legal range 1..255; Clk max 50 MHz at CLK_DIV=1.
- Clk  in  1  system clock; single clock domain.
- Reset  in  1  synchronous, active-high reset.
- Req  in  4  Req[i] = requester i wants DAC channel i written; level-sensitive.
- Value  in  64  channel i value at [16i+15:16i], two's complement; stable while Req[i] high.
- Ack  out  4  one-cycle pulse; Ack[i] high = Value[i] captured, frame for channel i started.
- Busy  out  1  high while a frame is in progress.
- nSync  out  1  DAC frame sync, active low.
- SClk  out  1  DAC serial clock, idles high.
- Data  out  1  serial data, MSB first, idles high.

## Operation
- Reset values, registered one edge after Reset high: nSync=1, SClk=1, Data=1, Ack=0, Busy=0, state IDLE, round-robin pointer=0 (channel 0 has highest priority).
- Arbitration, in IDLE only: grant = first i with Req[i]=1, searching from pointer upward with wrap 3→0. On grant, pointer ← grant+1 mod 4.
- Frame word: {2'b00, ld, 2'b00, ch[1:0], 1'b0, ~v[15], v[14:0]}, where v is the granted Value slice and ch is the granted index.
- ld=1 when Req with the granted bit masked is all-zero at the grant edge; otherwise ld=0.
- States and transitions:
  - IDLE: nSync=1, SClk=1, Data=1. Req≠0 → LEAD. On that edge: load the shift register, nSync←0, Ack[grant]←1, Busy←1.
  - LEAD: SClk=1 for CLK_DIV cycles, Data = frame bit 23 → LOW.
  - LOW: SClk=0 for CLK_DIV cycles → HIGH.
  - HIGH: SClk=1 for CLK_DIV cycles.
    - Entering HIGH from LOW shifts the register left (next bit on Data), except after bit 0.
    - After the HIGH that follows bit 0 → IDLE with nSync←1, Data←1, Busy←0.
- Ack is high only in the first cycle after the grant edge. A requester that keeps Req high through the frame is treated as a new request at the next IDLE.
- Bit counter counts 23 down to 0 and has no wrap. The CLK_DIV phase counter is 8 bits and reloads on every phase change.
- Reset mid-frame: frame abandoned and outputs return to reset values on the next edge. The partial frame is discarded by the DAC because nSync rises early. The pointer also resets.
- Req changes during a frame have no effect until IDLE. Value changes for a non-granted channel are harmless.

## Timing
- Req rising before edge k in IDLE → after edge k: nSync=0, Ack pulse, Busy=1.
- nSync low duration = 49·CLK_DIV cycles: LEAD + 24×(LOW+HIGH).
- nSync high between back-to-back frames = exactly 1 cycle (the IDLE cycle). Back-to-back period = 49·CLK_DIV+1 cycles, i.e. 50 at CLK_DIV=1.
- Data changes only at SClk rising edges, or at the nSync falling edge. The DAC samples on SClk falling edges.
- nSync→first SClk falling edge and last SClk rising edge→nSync rising edge are each ≥CLK_DIV cycles.
- Bit 23 is sampled on the first falling edge, bit 0 on the 24th.

## Test plan
- Single request: Req=4'b0100, Value[47:32]=16'h1234 → frame 24'h249234, one Ack[2] pulse, nSync low 49 cycles, Busy cleared with nSync rise.
- Burst: Req=4'b1111 held until each Ack → grants in order 0,1,2,3, each with 1-cycle nSync gaps. Control bytes are 8'h00, 8'h02, 8'h04, 8'h26; only the last frame has ld=1.
- Fairness: Req[0] held constantly, Req[1] raised once → grant order 0,1,0,0…, with channel 1 served as the second frame.
- Conversion: Value 16'h8000 → data 16'h0000; 16'h7FFF → 16'hFFFF; 16'hFFFF → 16'h7FFF.
- CLK_DIV=3: nSync low 147 cycles, SClk half-periods exactly 3 cycles, back-to-back period 148 cycles.
- Reset asserted at bit 10 of a frame → next edge: nSync=1, SClk=1, Data=1, Busy=0. A pending Req afterwards is granted to the lowest index first.

Source files
------------

// File: rtl/dac8564_scheduler.sv
// Round-robin arbiter and 24-bit serial frame engine for a quad DAC8564 on a shared
// nSync/SClk/Data bus; the frame that drains the pending queue carries the broadcast-load bit.
module dac8564_scheduler #(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [3:0]  Req,
    input  logic [63:0] Value,
    output logic [3:0]  Ack,
    output logic        Busy,
    output logic        nSync,
    output logic        SClk,
    output logic        Data
);
    typedef enum logic [1:0] {StIdle, StLead, StLow, StHigh} state_e;

    localparam logic [7:0] PhaseLoad = 8'(CLK_DIV - 1);

    state_e      state_q, state_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [7:0]  phase_q, phase_d;
    logic [4:0]  bitcnt_q, bitcnt_d;
    logic        last_q, last_d;
    logic [22:0] shift_q, shift_d;
    logic [3:0]  ack_q, ack_d;
    logic        busy_q, busy_d;
    logic        nsync_q, nsync_d;
    logic        sclk_q, sclk_d;
    logic        data_q, data_d;

    logic        gnt_valid;
    logic [1:0]  gnt;
    logic [1:0]  idx;
    logic        ld;
    logic [15:0] gnt_value;
    logic [23:0] frame;

    // Walk offsets downward so the lowest offset from the pointer wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt       = ptr_q;
        idx       = ptr_q;
        for (int off = 3; off >= 0; off--) begin
            idx = ptr_q + 2'(off);
            if (Req[idx]) begin
                gnt_valid = 1'b1;
                gnt       = idx;
            end
        end
        ld        = ((Req & ~(4'b0001 << gnt)) == 4'b0000);
        gnt_value = Value[{gnt, 4'b0000} +: 16];
        frame     = {2'b00, ld, 2'b00, gnt, 1'b0, ~gnt_value[15], gnt_value[14:0]};
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        phase_d  = phase_q;
        bitcnt_d = bitcnt_q;
        last_d   = last_q;
        shift_d  = shift_q;
        ack_d    = 4'b0000;
        busy_d   = busy_q;
        nsync_d  = nsync_q;
        sclk_d   = sclk_q;
        data_d   = data_q;
        case (state_q)
            StIdle: begin
                if (gnt_valid) begin
                    state_d  = StLead;
                    ptr_d    = gnt + 2'd1;
                    phase_d  = PhaseLoad;
                    bitcnt_d = 5'd23;
                    last_d   = 1'b0;
                    shift_d  = frame[22:0];
                    data_d   = frame[23];
                    ack_d    = 4'b0001 << gnt;
                    busy_d   = 1'b1;
                    nsync_d  = 1'b0;
                    sclk_d   = 1'b1;
                end
            end
            StLead: begin
                if (phase_q == 8'd0) begin
                    state_d = StLow;
                    phase_d = PhaseLoad;
                    sclk_d  = 1'b0;
                end else begin
                    phase_d = phase_q - 8'd1;
                end
            end
            StLow: begin
                if (phase_q == 8'd0) begin
                    state_d = StHigh;
                    phase_d = PhaseLoad;
                    sclk_d  = 1'b1;
                    // Bit 0 has just been sampled: hold Data and flag the closing HIGH.
                    if (bitcnt_q == 5'd0) begin
                        last_d = 1'b1;
                    end else begin
                        data_d   = shift_q[22];
                        shift_d  = {shift_q[21:0], 1'b0};
                        bitcnt_d = bitcnt_q - 5'd1;
                    end
                end else begin
                    phase_d = phase_q - 8'd1;
                end
            end
            StHigh: begin
                if (phase_q == 8'd0) begin
                    if (last_q) begin
                        state_d = StIdle;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        nsync_d = 1'b1;
                        data_d  = 1'b1;
                    end else begin
                        state_d = StLow;
                        phase_d = PhaseLoad;
                        sclk_d  = 1'b0;
                    end
                end else begin
                    phase_d = phase_q - 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= StIdle;
            ptr_q    <= 2'd0;
            phase_q  <= 8'd0;
            bitcnt_q <= 5'd0;
            last_q   <= 1'b0;
            shift_q  <= '0;
            ack_q    <= 4'b0000;
            busy_q   <= 1'b0;
            nsync_q  <= 1'b1;
            sclk_q   <= 1'b1;
            data_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            phase_q  <= phase_d;
            bitcnt_q <= bitcnt_d;
            last_q   <= last_d;
            shift_q  <= shift_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            nsync_q  <= nsync_d;
            sclk_q   <= sclk_d;
            data_q   <= data_d;
        end
    end

    assign Ack   = ack_q;
    assign Busy  = busy_q;
    assign nSync = nsync_q;
    assign SClk  = sclk_q;
    assign Data  = data_q;

endmodule

// File: tb/tb_dac8564_scheduler.sv
// Directed bench for dac8564_scheduler: table of single-channel frames plus burst,
// fairness, mid-frame reset and CLK_DIV=3 sequences, decoded from the serial pins.
module tb_dac8564_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req1, req3;
    logic [63:0] value1, value3;
    logic [3:0]  ack1, ack3;
    logic        busy1, busy3, nsync1, nsync3, sclk1, sclk3, data1, data3;

    int checks = 0;
    int failures = 0;

    logic       msel;
    logic [3:0] m_ack;
    logic       m_busy, m_nsync, m_sclk, m_data;

    assign m_ack   = msel ? ack3   : ack1;
    assign m_busy  = msel ? busy3  : busy1;
    assign m_nsync = msel ? nsync3 : nsync1;
    assign m_sclk  = msel ? sclk3  : sclk1;
    assign m_data  = msel ? data3  : data1;

    always #5 clk = ~clk;

    dac8564_scheduler #(.CLK_DIV(1)) dut1 (
        .Clk(clk), .Reset(rst), .Req(req1), .Value(value1), .Ack(ack1),
        .Busy(busy1), .nSync(nsync1), .SClk(sclk1), .Data(data1)
    );

    dac8564_scheduler #(.CLK_DIV(3)) dut3 (
        .Clk(clk), .Reset(rst), .Req(req3), .Value(value3), .Ack(ack3),
        .Busy(busy3), .nSync(nsync3), .SClk(sclk3), .Data(data3)
    );

    typedef struct {
        logic [1:0]  ch;
        logic [15:0] v;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Watches one frame on the selected DUT; drops acked Req bits not in keep.
    task automatic run_frame(input int d, input logic [3:0] keep, output logic [23:0] fr,
                             output int low, output logic [3:0] acks, output int ack_cnt,
                             output int wait_n, output int half_err, output int busy_err);
        logic prev;
        int   run;
        fr = '0; low = 0; acks = '0; ack_cnt = 0; wait_n = 0; half_err = 0; busy_err = 0;
        prev = 1'b1; run = 0;
        @(negedge clk);
        while (m_nsync && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        while (!m_nsync && low < 49 * d + 10) begin
            low++;
            if (m_ack != 4'b0000) begin
                acks |= m_ack;
                ack_cnt++;
            end
            if (msel) req3 = req3 & ~(m_ack & ~keep);
            else      req1 = req1 & ~(m_ack & ~keep);
            if (!m_busy) busy_err++;
            if (m_sclk == prev) begin
                run++;
            end else begin
                if (run != d) half_err++;
                if (!m_sclk) fr = {fr[22:0], m_data};
                prev = m_sclk;
                run  = 1;
            end
            @(negedge clk);
        end
        if (run != d) half_err++;
        if (m_busy || m_ack != 4'b0000 || !m_data || !m_sclk) busy_err++;
    endtask

    task automatic frame_check(input string tag, input int d, input logic [3:0] keep,
                               input logic [23:0] exp_fr, input logic [3:0] exp_ack,
                               output int wait_n);
        logic [23:0] fr;
        logic [3:0]  acks;
        int low, ack_cnt, half_err, busy_err;
        run_frame(d, keep, fr, low, acks, ack_cnt, wait_n, half_err, busy_err);
        check({tag, " frame"}, 32'(fr), 32'(exp_fr));
        check({tag, " ack"}, 32'(acks), 32'(exp_ack));
        check({tag, " ack_pulses"}, ack_cnt, 1);
        check({tag, " nsync_low"}, low, 49 * d);
        check({tag, " sclk_half"}, half_err, 0);
        check({tag, " busy_idle"}, busy_err, 0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, " nSync"}, 32'(m_nsync), 1);
        check({tag, " SClk"}, 32'(m_sclk), 1);
        check({tag, " Data"}, 32'(m_data), 1);
        check({tag, " Busy"}, 32'(m_busy), 0);
        check({tag, " Ack"}, 32'(m_ack), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wn;
        int n;
        vecs[0] = '{2'd2, 16'h1234, 24'h249234};
        vecs[1] = '{2'd0, 16'h8000, 24'h200000};
        vecs[2] = '{2'd1, 16'h7FFF, 24'h22FFFF};
        vecs[3] = '{2'd3, 16'hFFFF, 24'h267FFF};
        vecs[4] = '{2'd0, 16'h0000, 24'h208000};
        vecs[5] = '{2'd1, 16'hABCD, 24'h222BCD};

        rst = 1'b1; req1 = '0; req3 = '0; value1 = '0; value3 = '0; msel = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        msel = 1'b0;
        check_idle("reset div1");
        msel = 1'b1;
        check_idle("reset div3");
        msel = 1'b0;
        rst = 1'b0;

        // Single requests; unrelated Value slices hold garbage.
        for (int i = 0; i < 6; i++) begin
            value1 = {4{16'hDEAD}};
            value1[int'(vecs[i].ch) * 16 +: 16] = vecs[i].v;
            req1 = 4'b0001 << vecs[i].ch;
            frame_check($sformatf("vec%0d", i), 1, 4'b0000, vecs[i].exp,
                        4'b0001 << vecs[i].ch, wn);
        end

        // Burst: all four pending, each dropped on its Ack.
        do_reset();
        value1 = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        req1 = 4'b1111;
        frame_check("burst0", 1, 4'b0000, 24'h009111, 4'b0001, wn);
        frame_check("burst1", 1, 4'b0000, 24'h02A222, 4'b0010, wn);
        check("burst1 gap", wn, 0);
        frame_check("burst2", 1, 4'b0000, 24'h04B333, 4'b0100, wn);
        check("burst2 gap", wn, 0);
        frame_check("burst3", 1, 4'b0000, 24'h26C444, 4'b1000, wn);
        check("burst3 gap", wn, 0);

        // Fairness: Req[0] held, Req[1] raised once.
        do_reset();
        value1 = {16'h0000, 16'h0000, 16'h0101, 16'h0202};
        req1 = 4'b0011;
        frame_check("fair0", 1, 4'b0001, 24'h008202, 4'b0001, wn);
        frame_check("fair1", 1, 4'b0001, 24'h028101, 4'b0010, wn);
        frame_check("fair2", 1, 4'b0001, 24'h208202, 4'b0001, wn);
        frame_check("fair3", 1, 4'b0001, 24'h208202, 4'b0001, wn);
        req1 = 4'b0000;

        // Reset while bit 10 is on the wire, then pointer must be back at 0.
        repeat (2) @(negedge clk);
        value1 = {16'h0000, 16'h0000, 16'h5555, 16'h0000};
        req1 = 4'b0010;
        n = 0;
        @(negedge clk);
        while (nsync1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("midreset start", 32'(nsync1), 0);
        req1 = 4'b0000;
        repeat (27) @(negedge clk);
        check("midreset busy_before", 32'(busy1), 1);
        check("midreset sclk_low_at_bit10", 32'(sclk1), 0);
        rst = 1'b1;
        @(negedge clk);
        check_idle("midreset");
        rst = 1'b0;
        value1 = {16'h0000, 16'h0B0B, 16'h0A0A, 16'h0000};
        req1 = 4'b0110;
        frame_check("after_reset0", 1, 4'b0000, 24'h028A0A, 4'b0010, wn);
        frame_check("after_reset1", 1, 4'b0000, 24'h248B0B, 4'b0100, wn);
        check("after_reset1 gap", wn, 0);

        // CLK_DIV=3: 147-cycle frames, 148-cycle back-to-back period.
        msel = 1'b1;
        value3 = {16'h0000, 16'h0000, 16'h8000, 16'h1234};
        req3 = 4'b0011;
        frame_check("div3_0", 3, 4'b0000, 24'h009234, 4'b0001, wn);
        frame_check("div3_1", 3, 4'b0000, 24'h220000, 4'b0010, wn);
        check("div3_1 gap", wn, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
